transconv_seq: RTL

Sequencer for the stride-2, 3x3 transposed-convolution datapath (`transconv`). It walks an input feature map held in a synchronous-read feature RAM and drives the datapath's `rw`, `hop` and `flip` controls. It tags every emitted output pixel with its row and column. It sits between the layer-level controller (`start` / `done`) and one `transconv` instance plus its feature RAM.

---
 rtl/transconv_pkg.sv | 21 ++
 rtl/transconv_rowcol_cnt.sv | 34 +++
 rtl/transconv_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/transconv_pkg.sv
// Shared types and constants for the stride-2 3x3 transposed-convolution sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package transconv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } tc_state_e;

    localparam int TC_KERNEL = 3;
    localparam int TC_STRIDE = 2;

    // Output row width for an input row of w pixels: stride*w + 1.
    function automatic logic [15:0] ow_of(input logic [7:0] w);
        return 16'(TC_STRIDE) * {8'd0, w} + 16'd1;
    endfunction

endpackage

// File: rtl/transconv_rowcol_cnt.sv
// Wrapping row/column tag counter: col runs 0..col_last, then wraps and bumps row.
// Latency: new value visible the cycle after load/en.
// Backpressure: none; advances on every en cycle.
module transconv_rowcol_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_row,
    input  logic [15:0] load_col,
    input  logic        en,
    input  logic [15:0] col_last,
    output logic [15:0] row,
    output logic [15:0] col
);

    // Load takes priority over counting; column wrap carries into the row.
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= 16'd0;
            col <= 16'd0;
        end else if (load) begin
            row <= load_row;
            col <= load_col;
        end else if (en) begin
            if (col == col_last) begin
                col <= 16'd0;
                row <= row + 16'd1;
            end else begin
                col <= col + 16'd1;
            end
        end
    end

endmodule

// File: rtl/transconv_seq.sv
// Sequencer walking the input map and driving transconv rw/hop/flip, tagging output pixels.
// Latency: first feat_en one cycle after start, first tc_rw two cycles, out_valid = emit flag + 2.
// Backpressure: none; the consumer must take one pixel per out_valid cycle.
import transconv_pkg::*;

module transconv_seq #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        width,
    input  logic [7:0]        height,
    output logic              feat_en,
    output logic [ADDR_W-1:0] feat_addr,
    output logic              tc_rw,
    output logic              tc_hop,
    output logic              tc_flip,
    output logic              out_valid,
    output logic [15:0]       out_row,
    output logic [15:0]       out_col,
    output logic              busy,
    output logic              done,
    output logic              err
);

    tc_state_e   state_q, state_nxt;
    logic [7:0]  w_q, h_q;
    logic [15:0] r_q;       // current input row
    logic [15:0] c_q;       // column within the LOAD burst
    logic [15:0] win_q;     // cycle within the emit window
    logic [1:0]  drain_q;   // DONE waits for the emit pipeline to drain
    logic        flip_q;
    logic        rw_q;
    logic        win_d1, win_d2;
    logic        err_q;

    logic        accept, zero_start, reject, load_last, win_last;
    logic        zero_dim, too_big, last_row;
    logic [15:0] ow, win_len, row_base, addr_sum;

    assign zero_dim = (width == 8'd0) || (height == 8'd0);
    assign too_big  = (int'({24'd0, width}) > IMAGE_WIDTH / 2) ||
                      (int'({24'd0, height}) > IMAGE_HEIGHT);
    assign ow       = ow_of(w_q);
    assign last_row = (r_q == ({8'd0, h_q} - 16'd1));
    // The last window runs an extra output row to flush the trailing partial row.
    assign win_len  = last_row ? (ow + ow + ow) : (ow + ow);
    // r*W as an 8x8 product; r never exceeds H-1 so the low byte is exact.
    assign row_base = 16'(r_q[7:0]) * 16'(w_q);
    assign addr_sum = row_base + c_q;

    assign feat_en   = (state_q == ST_LOAD);
    assign feat_addr = feat_en ? ADDR_W'(addr_sum) : '0;
    assign tc_rw     = rw_q;
    assign tc_hop    = rw_q;
    assign tc_flip   = flip_q;
    assign out_valid = win_d2;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE) && (drain_q == 2'd2);
    assign err       = err_q;

    // State register; abort and reset both force IDLE.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_nxt  = state_q;
        accept     = 1'b0;
        zero_start = 1'b0;
        reject     = 1'b0;
        load_last  = 1'b0;
        win_last   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (zero_dim) begin
                        state_nxt  = ST_DONE;
                        zero_start = 1'b1;
                    end else if (too_big) begin
                        reject = 1'b1;
                    end else begin
                        state_nxt = ST_LOAD;
                        accept    = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (c_q == ({8'd0, w_q} - 16'd1)) begin
                    state_nxt = ST_EMIT;
                    load_last = 1'b1;
                end
            end
            ST_EMIT: begin
                if (win_q == (win_len - 16'd1)) begin
                    win_last  = 1'b1;
                    state_nxt = last_row ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                if (drain_q == 2'd2) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Layer registers, burst/window counters and the rw / emit-flag delay pipeline.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            w_q     <= 8'd0;
            h_q     <= 8'd0;
            r_q     <= 16'd0;
            c_q     <= 16'd0;
            win_q   <= 16'd0;
            drain_q <= 2'd0;
            flip_q  <= 1'b0;
            rw_q    <= 1'b0;
            win_d1  <= 1'b0;
            win_d2  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rw_q   <= feat_en;
            win_d1 <= (state_q == ST_EMIT);
            win_d2 <= win_d1;
            err_q  <= reject;
            c_q    <= (feat_en && !load_last) ? c_q + 16'd1 : 16'd0;
            win_q  <= ((state_q == ST_EMIT) && !win_last) ? win_q + 16'd1 : 16'd0;
            if (accept) begin
                w_q    <= width;
                h_q    <= height;
                r_q    <= 16'd0;
                flip_q <= 1'b0;
            end
            if (win_last && !last_row) begin
                r_q    <= r_q + 16'd1;
                flip_q <= ~flip_q;
            end
            // Empty layers skip the drain; otherwise wait two cycles for out_valid to finish.
            if (zero_start) begin
                drain_q <= 2'd2;
            end else if (state_q == ST_DONE) begin
                drain_q <= (drain_q == 2'd2) ? 2'd0 : drain_q + 2'd1;
            end
        end
    end

    transconv_rowcol_cnt u_tag (
        .clk      (clk),
        .rst      (rst),
        .load     (accept || abort),
        .load_row (16'd0),
        .load_col (16'd0),
        .en       (win_d2),
        .col_last (ow - 16'd1),
        .row      (out_row),
        .col      (out_col)
    );

endmodule
